// File: rtl/vram_write_arbiter.sv
// vram_write_arbiter: round-robin arbiter for the CPU/DMA write paths into the single video memory bridge port.
// Define VRAM_ARB_STATS_EN to implement the frame_count refresh counter (tied to zero otherwise).
module vram_write_arbiter #(
  parameter logic [31:0] VRAM_BASE_ADDR = 32'h8000,
  parameter int          VRAM_WORDS     = 76800,
  parameter logic [31:0] REFRESH_ADDR   = 32'h54000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_valid,
  output logic        cpu_ready,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_data,
  input  logic        dma_valid,
  output logic        dma_ready,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_data,
  output logic        vm_we,
  output logic [31:0] vm_address,
  output logic [31:0] vm_data,
  output logic        err_drop,
  output logic [15:0] frame_count
);
  typedef enum logic [1:0] {NORMAL, DRAIN, COMMIT} state_t;
  localparam logic [32:0] lo = {1'b0, VRAM_BASE_ADDR};
  localparam logic [32:0] hi = lo + 33'(4 * VRAM_WORDS);
  state_t      state;
  logic        owner, last_grant;
  logic        cf, df;
  logic [31:0] ca, cd, da, dd;
  logic        c_ref, d_ref, c_ok, d_ok, e_c, e_d, g_c, g_d, commit, any, sel_ok, write, drop, other_clear;
  assign c_ref = ca == REFRESH_ADDR;
  assign d_ref = da == REFRESH_ADDR;
  assign c_ok = ca[1:0] == 2'b00 && {1'b0, ca} >= lo && {1'b0, ca} < hi;
  assign d_ok = da[1:0] == 2'b00 && {1'b0, da} >= lo && {1'b0, da} < hi;
  // owner: 0 = CPU holds the barrier refresh, 1 = DMA
  assign e_c = cf & !c_ref & (state == NORMAL | (state == DRAIN & owner));
  assign e_d = df & !d_ref & (state == NORMAL | (state == DRAIN & !owner));
  assign commit = state == COMMIT;
  assign g_c = (e_c & (!e_d | last_grant)) | (commit & !owner);
  assign g_d = (e_d & !(e_c & (!e_d | last_grant))) | (commit & owner);
  assign any = g_c | g_d;
  assign sel_ok = g_d ? d_ok : c_ok;
  assign write = commit | (any & sel_ok);
  assign drop = any & !commit & !sel_ok;
  assign other_clear = owner ? (!cf | c_ref) : (!df | d_ref);
  assign cpu_ready = (!cf | g_c) & !(state != NORMAL & owner);
  assign dma_ready = (!df | g_d) & !(state != NORMAL & !owner);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= NORMAL;
      owner <= 1'b0;
      last_grant <= 1'b1;
      cf <= 1'b0;
      df <= 1'b0;
      ca <= '0;
      cd <= '0;
      da <= '0;
      dd <= '0;
      vm_we <= 1'b0;
      vm_address <= '0;
      vm_data <= '0;
      err_drop <= 1'b0;
    end else begin
      if (cpu_valid & cpu_ready) begin
        cf <= 1'b1;
        ca <= cpu_addr;
        cd <= cpu_data;
      end else if (g_c) cf <= 1'b0;
      if (dma_valid & dma_ready) begin
        df <= 1'b1;
        da <= dma_addr;
        dd <= dma_data;
      end else if (g_d) df <= 1'b0;
      if (any) last_grant <= g_d;
      vm_we <= write;
      err_drop <= drop;
      if (write) begin
        vm_address <= commit ? REFRESH_ADDR : (g_d ? da : ca);
        vm_data <= g_d ? dd : cd;
      end
      // CPU refresh wins when both ports hold one; the DMA refresh waits for the next barrier
      if (state == NORMAL && cf && c_ref) begin
        state <= DRAIN;
        owner <= 1'b0;
      end else if (state == NORMAL && df && d_ref) begin
        state <= DRAIN;
        owner <= 1'b1;
      end else if (state == DRAIN && other_clear) state <= COMMIT;
      else if (commit) state <= NORMAL;
    end
  end
`ifdef VRAM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_count <= '0;
    else if (commit) frame_count <= frame_count + 16'd1;
  end
`else
  assign frame_count = 16'h0;
`endif
endmodule

// File: tb/tb_vram_write_arbiter.sv
// tb_vram_write_arbiter: directed checks of arbitration, refresh barrier, range filtering and reset.
module tb_vram_write_arbiter;
`ifdef VRAM_ARB_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cpu_valid = 1'b0, dma_valid = 1'b0;
  logic        cpu_ready, dma_ready;
  logic [31:0] cpu_addr = '0, cpu_data = '0, dma_addr = '0, dma_data = '0;
  logic        vm_we, err_drop;
  logic [31:0] vm_address, vm_data;
  logic [15:0] frame_count;
  int          vectors = 0, errors = 0;

  vram_write_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .dma_valid(dma_valid), .dma_ready(dma_ready), .dma_addr(dma_addr), .dma_data(dma_data),
    .vm_we(vm_we), .vm_address(vm_address), .vm_data(vm_data),
    .err_drop(err_drop), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int ci, di;
    logic acc_c, acc_d;
    logic [31:0] bad [4];
    bad[0] = 32'h54004; bad[1] = 32'h8002; bad[2] = 32'h7FFC; bad[3] = 32'h53000;
    step();
    chk("rst_vm_we", 32'(vm_we), 32'd0);
    chk("rst_vm_address", vm_address, 32'd0);
    chk("rst_vm_data", vm_data, 32'd0);
    chk("rst_err_drop", 32'(err_drop), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    chk("rst_cpu_ready", 32'(cpu_ready), 32'd1);
    chk("rst_dma_ready", 32'(dma_ready), 32'd1);
    rst_n = 1'b1;
    step();
    // single CPU write, two-edge latency
    cpu_valid = 1'b1; cpu_addr = 32'h8000; cpu_data = 32'hDEADBEEF;
    step();
    cpu_valid = 1'b0;
    chk("single_we_early", 32'(vm_we), 32'd0);
    chk("single_cpu_ready", 32'(cpu_ready), 32'd1);
    step();
    chk("single_we", 32'(vm_we), 32'd1);
    chk("single_addr", vm_address, 32'h8000);
    chk("single_data", vm_data, 32'hDEADBEEF);
    step();
    chk("single_we_off", 32'(vm_we), 32'd0);
    chk("single_addr_hold", vm_address, 32'h8000);
    // contested: writes alternate CPU, DMA starting with CPU after reset
    reset_dut();
    ci = 0; di = 0;
    for (int k = 1; k <= 8; k++) begin
      cpu_valid = 1'b1; cpu_addr = 32'h8000 + 32'(4 * ci); cpu_data = 32'hC000_0000 | 32'(ci);
      dma_valid = 1'b1; dma_addr = 32'h9000 + 32'(4 * di); dma_data = 32'hD000_0000 | 32'(di);
      acc_c = cpu_ready; acc_d = dma_ready;
      step();
      if (acc_c) ci++;
      if (acc_d) di++;
      if (k == 1) chk("rr_we_first", 32'(vm_we), 32'd0);
      else if (k % 2 == 0) begin
        chk("rr_we_cpu", 32'(vm_we), 32'd1);
        chk("rr_addr_cpu", vm_address, 32'h8000 + 32'(4 * ((k - 2) / 2)));
        chk("rr_data_cpu", vm_data, 32'hC000_0000 | 32'((k - 2) / 2));
      end else begin
        chk("rr_we_dma", 32'(vm_we), 32'd1);
        chk("rr_addr_dma", vm_address, 32'h9000 + 32'(4 * ((k - 3) / 2)));
        chk("rr_data_dma", vm_data, 32'hD000_0000 | 32'((k - 3) / 2));
      end
    end
    cpu_valid = 1'b0; dma_valid = 1'b0;
    repeat (4) step();
    chk("rr_idle", 32'(vm_we), 32'd0);
    // refresh barrier: DMA 0x8004 drains before CPU refresh commits
    dma_valid = 1'b1; dma_addr = 32'h8004; dma_data = 32'h1111_1111;
    cpu_valid = 1'b1; cpu_addr = 32'h54000; cpu_data = 32'h2222_2222;
    step();
    cpu_valid = 1'b0; dma_valid = 1'b0;
    chk("bar_we0", 32'(vm_we), 32'd0);
    step();
    chk("bar_dma_we", 32'(vm_we), 32'd1);
    chk("bar_dma_addr", vm_address, 32'h8004);
    chk("bar_dma_data", vm_data, 32'h1111_1111);
    chk("bar_drain_dma_ready", 32'(dma_ready), 32'd0);
    chk("bar_drain_cpu_ready", 32'(cpu_ready), 32'd0);
    step();
    chk("bar_gap_we", 32'(vm_we), 32'd0);
    chk("bar_commit_dma_ready", 32'(dma_ready), 32'd0);
    chk("bar_fc_before", 32'(frame_count), 32'd0);
    step();
    chk("bar_ref_we", 32'(vm_we), 32'd1);
    chk("bar_ref_addr", vm_address, 32'h54000);
    chk("bar_ref_data", vm_data, 32'h2222_2222);
    chk("bar_fc_after", 32'(frame_count), 32'(STATS));
    chk("bar_dma_ready_back", 32'(dma_ready), 32'd1);
    step();
    chk("bar_we_off", 32'(vm_we), 32'd0);
    // out-of-range and misaligned addresses are dropped
    for (int i = 0; i < 4; i++) begin
      cpu_valid = 1'b1; cpu_addr = bad[i]; cpu_data = 32'hBAD0_0000 | 32'(i);
      step();
      cpu_valid = 1'b0;
      step();
      chk("bad_err_drop", 32'(err_drop), 32'd1);
      chk("bad_no_we", 32'(vm_we), 32'd0);
      step();
      chk("bad_err_off", 32'(err_drop), 32'd0);
    end
    // last frame-buffer word is a normal write
    cpu_valid = 1'b1; cpu_addr = 32'h52FFC; cpu_data = 32'h0000_ABCD;
    step();
    cpu_valid = 1'b0;
    step();
    chk("last_we", 32'(vm_we), 32'd1);
    chk("last_addr", vm_address, 32'h52FFC);
    chk("last_err", 32'(err_drop), 32'd0);
    // refresh alone: vm_we three edges after acceptance
    cpu_valid = 1'b1; cpu_addr = 32'h54000; cpu_data = 32'h0000_5555;
    step();
    cpu_valid = 1'b0;
    step();
    chk("ref2_we_e1", 32'(vm_we), 32'd0);
    step();
    chk("ref2_we_e2", 32'(vm_we), 32'd0);
    step();
    chk("ref2_we", 32'(vm_we), 32'd1);
    chk("ref2_addr", vm_address, 32'h54000);
    chk("ref2_err", 32'(err_drop), 32'd0);
    chk("ref2_fc", 32'(frame_count), 32'(2 * STATS));
    step();
    // reset with both holding registers full
    cpu_valid = 1'b1; cpu_addr = 32'h8100; cpu_data = 32'h3333_3333;
    dma_valid = 1'b1; dma_addr = 32'h9100; dma_data = 32'h4444_4444;
    step();
    cpu_valid = 1'b0; dma_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(vm_we), 32'd0);
    chk("mid_rst_fc", 32'(frame_count), 32'd0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("post_rst_we", 32'(vm_we), 32'd0);
    end
    chk("post_rst_cpu_ready", 32'(cpu_ready), 32'd1);
    chk("post_rst_dma_ready", 32'(dma_ready), 32'd1);
    chk("post_rst_fc", 32'(frame_count), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
